// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity/data constants and the
// majority-vote helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam int   DATA_WIDTH  = 8;

  // Wide enough for edge counts up to PRESCALE = 32.
  localparam int   EDGE_W      = 5;
  localparam int   BIT_W       = 4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Mid-bit oversampler: captures rx_s at the two cycles before the decision
// point and votes them against the live sample at the decision cycle.
module data_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_s,
  input  logic [EDGE_W-1:0] edge_cnt,
  input  logic              enable,
  output logic              sampled_bit,
  output logic              sample_done
);

  localparam logic [EDGE_W-1:0] SAMPLE_A = EDGE_W'(PRESCALE / 2 - 1);
  localparam logic [EDGE_W-1:0] SAMPLE_B = EDGE_W'(PRESCALE / 2);
  localparam logic [EDGE_W-1:0] DECIDE   = EDGE_W'(PRESCALE / 2 + 1);

  logic [1:0] samples;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples <= '0;
    end else if (enable) begin
      if (edge_cnt == SAMPLE_A) samples[0] <= rx_s;
      if (edge_cnt == SAMPLE_B) samples[1] <= rx_s;
    end
  end

  // Third vote is taken live so the bit is known in the decision cycle itself.
  assign sample_done = enable && (edge_cnt == DECIDE);
  assign sampled_bit = majority3(samples[0], samples[1], rx_s);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes RX_IN, frames start/data/parity/stop bits with
// a majority-voted mid-bit sample and reports the byte or frame errors.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | validating start bit, glitch returns to IDLE
// DATA   | shifting in 8 data bits LSB first
// PARITY | checking optional parity bit
// STOP   | sampling stop bit, publishing result
module uart_rx
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  parity_enable,
  input  logic                  Parity_Type,
  output logic [DATA_WIDTH-1:0] P_Data,
  output logic                  Data_Valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(PRESCALE - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_WIDTH);

  state_t                  state, state_next;
  logic                    sync_1, rx_s;
  logic [EDGE_W-1:0]       edge_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    par_en_q, par_type_q, par_flag;
  logic                    sampled_bit, sample_done;
  logic                    wrap, exp_parity, start_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= RX_IN;
      rx_s   <= sync_1;
    end
  end

  data_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx_s       (rx_s),
    .edge_cnt   (edge_cnt),
    .enable     (busy),
    .sampled_bit(sampled_bit),
    .sample_done(sample_done)
  );

  assign busy       = (state != IDLE);
  assign wrap       = (edge_cnt == EDGE_LAST);
  assign start_seen = (state == IDLE) && !rx_s;
  assign exp_parity = (^shift_reg) ^ (par_type_q == PARITY_ODD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (!rx_s) state_next = START;
      START: begin
        if (sample_done && sampled_bit) state_next = IDLE;
        else if (wrap)                  state_next = DATA;
      end
      DATA:   if (wrap && bit_cnt == LAST_DATA) state_next = par_en_q ? PARITY : STOP;
      PARITY: if (wrap) state_next = STOP;
      // Leave before the wrap so a start bit right after the stop bit is caught.
      STOP:   if (sample_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The IDLE cycle that sees rx_s low already counts as edge 0 of the start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (start_seen) begin
      edge_cnt <= EDGE_W'(1);
      bit_cnt  <= '0;
    end else if (state == IDLE || state_next == IDLE) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BIT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + EDGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_q   <= 1'b0;
      par_type_q <= PARITY_EVEN;
      par_flag   <= 1'b0;
      shift_reg  <= '0;
    end else begin
      if (start_seen) begin
        par_en_q   <= parity_enable;
        par_type_q <= Parity_Type;
        par_flag   <= 1'b0;
      end
      if (state == DATA && sample_done)
        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
      if (state == PARITY && sample_done)
        par_flag <= (sampled_bit != exp_parity);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      P_Data       <= '0;
      Data_Valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      if (state == STOP && sample_done) begin
        parity_error <= par_flag;
        stop_error   <= !sampled_bit;
        if (sampled_bit && !par_flag) begin
          P_Data     <= shift_reg;
          Data_Valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver queues hand-computed frame results,
// a negedge monitor pops them whenever an output pulse appears.
module tb_uart_rx;

  localparam int PRESCALE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX_IN = 1'b1;
  logic       parity_enable = 1'b0;
  logic       Parity_Type = 1'b0;
  logic [7:0] P_Data;
  logic       Data_Valid, parity_error, stop_error, busy;

  uart_rx #(.PRESCALE(PRESCALE)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_IN        (RX_IN),
    .parity_enable(parity_enable),
    .Parity_Type  (Parity_Type),
    .P_Data       (P_Data),
    .Data_Valid   (Data_Valid),
    .parity_error (parity_error),
    .stop_error   (stop_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind = {Data_Valid, parity_error, stop_error}
  typedef struct {
    logic [2:0] kind;
    logic [7:0] pdata;
    int         at;
  } exp_t;

  exp_t q[$];

  logic       probe_busy;
  logic [7:0] probe_pdata;
  int         probe_req = 0;
  int         probe_ack = 0;
  logic       done = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every comparison and both counters live in this one process.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (Data_Valid || parity_error || stop_error) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {Data_Valid, parity_error, stop_error}, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", {Data_Valid, parity_error, stop_error}, e.kind);
          chk("p_data", P_Data, e.pdata);
          chk("pulse_cycle", cyc, e.at);
        end
      end
      if (probe_req != probe_ack) begin
        probe_ack = probe_req;
        chk("probe_busy", busy, probe_busy);
        chk("probe_p_data", P_Data, probe_pdata);
        chk("probe_pulses", {Data_Valid, parity_error, stop_error}, 0);
      end
      if (done) begin
        chk("pending_frames", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
      end
    end
  end

  task automatic probe(input logic b, input logic [7:0] pd);
    probe_busy  = b;
    probe_pdata = pd;
    probe_req++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; glitch_bit (frame bit index, 0=start) gets a one-cycle
  // inversion at edge 4; flip_cfg toggles the config inputs mid-frame.
  task automatic send_frame(input logic [7:0] data, input logic pen, input logic ptype,
                            input logic pbit, input logic sbit, input int glitch_bit,
                            input logic flip_cfg, input logic [2:0] kind,
                            input logic [7:0] exp_pd);
    logic bits[11];
    int   nb;
    exp_t e;
    parity_enable = pen;
    Parity_Type   = ptype;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    nb = 9;
    if (pen) begin bits[nb] = pbit; nb++; end
    bits[nb] = sbit;
    nb++;
    e.kind  = kind;
    e.pdata = exp_pd;
    // Frame start (RX_IN fall) + 2 sync cycles + 78 (no parity) / 86 (parity).
    e.at    = cyc + (pen ? 88 : 80);
    q.push_back(e);
    for (int b = 0; b < nb; b++) begin
      RX_IN = bits[b];
      if (flip_cfg && b == 3) begin
        parity_enable = ~pen;
        Parity_Type   = ~ptype;
      end
      if (b == glitch_bit) begin
        idle(4);
        RX_IN = ~bits[b];
        idle(1);
        RX_IN = bits[b];
        idle(PRESCALE - 5);
      end else begin
        idle(PRESCALE);
      end
    end
    parity_enable = pen;
    Parity_Type   = ptype;
  endtask

  initial begin
    idle(1);
    probe(1'b0, 8'h00);
    idle(3);
    rst = 1'b0;
    idle(10);

    // 1: plain frame, config toggled mid-frame must be ignored
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 3'b100, 8'hA5);
    idle(20);
    // 2: even parity good then bad
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, 3'b100, 8'h3C);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, 3'b010, 8'h3C);
    idle(20);
    // 3: odd parity good, then stop bit low
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0, 3'b100, 8'h01);
    idle(20);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0, 3'b001, 8'h01);
    RX_IN = 1'b1;
    idle(30);
    probe(1'b0, 8'h01);
    idle(5);

    // 4: three-cycle glitch on idle line
    parity_enable = 1'b0;
    RX_IN = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    idle(1);
    probe(1'b1, 8'h01);
    idle(8);
    probe(1'b0, 8'h01);
    idle(10);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 3'b100, 8'h7E);
    idle(20);

    // 5: back-to-back frames
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 3'b100, 8'h12);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 3'b100, 8'h34);
    idle(20);

    // 6: reset inside data bit 4 of 0xFF
    RX_IN = 1'b0;
    idle(PRESCALE);
    RX_IN = 1'b1;
    idle(4 * PRESCALE);
    probe(1'b1, 8'h34);
    idle(3);
    rst = 1'b1;
    probe(1'b0, 8'h00);
    idle(3);
    rst = 1'b0;
    idle(20);
    probe(1'b0, 8'h00);
    idle(5);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 3'b100, 8'h0F);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 3'b100, 8'hC3);
    idle(100);
    done = 1'b1;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: oversamples the serial line RX_IN, detects the start bit and recovers 8 data bits LSB-first, an optional parity bit and one stop bit.
- Presents the recovered byte on P_Data with a one-cycle Data_Valid pulse.
- Mirrors the transmitter's frame format: idle-high line, start=0, 8 data bits, optional even/odd parity, stop=1.
- Sits at the receive pin of the UART and feeds the byte consumer directly. There is no FIFO.

Parameters:
- PRESCALE, 8: clk cycles per bit. Must be even and ≥ 6. Legal values are 8, 16, 32.

Ports:
- clk  input  1  oversampling clock (bit rate × PRESCALE)
- rst  input  1  asynchronous, active-high reset
- RX_IN  input  1  serial line, asynchronous to clk, idles high
- parity_enable  input  1  1 = frame carries a parity bit after data bit 7
- Parity_Type  input  1  0 = even, 1 = odd
- P_Data  output  8  last correctly received byte
- Data_Valid  output  1  one-cycle pulse when P_Data is updated
- parity_error  output  1  one-cycle pulse when a parity mismatch is detected
- stop_error  output  1  one-cycle pulse when the stop bit samples 0
- busy  output  1  high while the state is not IDLE

Behaviour:
- Reset values: P_Data=0, Data_Valid=0, parity_error=0, stop_error=0, busy=0, state=IDLE, counters=0. The synchronizer flops reset to 1.
- Input path:
  - RX_IN passes through a 2-flop synchronizer; its output is rx_s.
  - All timing below is relative to rx_s, which lags RX_IN by 2 cycles.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 and wraps to 0 at PRESCALE-1.
  - bit_cnt increments on each wrap.
- Sampling:
  - rx_s is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the 2-of-3 majority of those samples.
  - The bit is decided in the cycle with edge_cnt = PRESCALE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s = 0, go to START. That cycle is edge_cnt 0 of bit 0.
  - START:
    - Majority = 1: treated as a glitch. Return to IDLE at the decision cycle+1 with no output pulse.
    - Majority = 0: continue. Go to DATA at the edge_cnt wrap.
  - DATA:
    - Shift the decided bit into a shift register, LSB first.
    - After the 8th bit wraps, go to PARITY if parity_enable, else STOP.
  - PARITY:
    - Expected parity = XOR of the 8 data bits, inverted when Parity_Type = 1.
    - A mismatch sets an internal flag.
    - Go to STOP at the wrap.
  - STOP: at the decision cycle, evaluate the frame and go to IDLE in the next cycle without waiting for the wrap, so a back-to-back start is caught.
- Outputs, one cycle after the stop decision:
  - Stop bit = 1 and no parity flag: P_Data ← shift register and Data_Valid = 1.
  - Parity flag set: parity_error = 1. P_Data is held and Data_Valid stays 0.
  - Stop bit = 0: stop_error = 1. P_Data is held. Both error pulses fire together if both conditions hold.
- Configuration sampling: parity_enable and Parity_Type are sampled at the IDLE→START transition and held for the frame. Mid-frame changes are ignored.
- Latency, PRESCALE=8, no parity: Data_Valid is high in cycle 78, counting the first rx_s-low cycle as cycle 0. With parity it is cycle 86.
- Reset mid-frame: all outputs and state clear immediately. No partial byte is ever presented.
- Outputs between frames: all pulses are exactly 1 cycle wide, and P_Data holds its value between frames.

Decomposition:
- Shared package uart_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Constants: PARITY_EVEN=0, PARITY_ODD=1, DATA_WIDTH=8.
  - The transmitter uses the same constants.
- Sub-module data_sampler:
  - Owns the three-sample register and the majority vote.
  - Inputs: rx_s, edge_cnt, enable.
  - Outputs: sampled_bit, sample_done.
- The FSM, counters, shift register and checks stay in uart_rx.

Test Plan:
1. PRESCALE=8, parity off, send frame for 0xA5 -> Data_Valid single pulse at cycle 78 after rx_s falls, P_Data=0xA5, no error pulses.
2. Parity on, even, send 0x3C with parity bit 0 -> Data_Valid, P_Data=0x3C. Repeat with parity bit 1 -> parity_error pulse, Data_Valid stays 0, P_Data remains 0x3C.
3. Parity on, odd, send 0x01 with parity bit 0 -> P_Data=0x01, Data_Valid. Then send 0x55 with stop bit 0 -> stop_error pulse, P_Data remains 0x01.
4. 3-cycle low glitch on an idle line -> busy rises then returns to 0, no Data_Valid or error pulses. A following frame 0x7E is received correctly.
5. Back-to-back frames 0x12 then 0x34 with zero idle time between them -> two Data_Valid pulses 80 cycles apart, P_Data=0x12 then 0x34.
6. Assert rst during data bit 4 of frame 0xFF -> all outputs 0 immediately. The next frame 0x0F gives P_Data=0x0F. A single-cycle inverted sample at edge_cnt=4 of a data bit does not change the received byte.
